// File: rtl/inst_fetch.sv
// inst_fetch: IF stage of the RV32I pipeline: fetch PC, req/ack imem port, IF/ID register.
// Optional IF_BUF_EN: replaces the single hold register with a BUF_DEPTH-entry fetch FIFO.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        if_flush_i,
  input  logic        jmp_i,
  input  logic [31:0] pc_branch_i,
  input  logic [31:0] pc_jmp_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_fetch_pc, w_fetch_pc, r_drop_pc, w_drop_pc;
  logic [31:0] r_pc, w_pc, r_inst, w_inst;
  logic        r_valid, w_valid;
  logic [31:0] w_target;
  if (BUF_DEPTH < 1) begin : g_bad_depth
    $error("BUF_DEPTH must be at least 1");
  end
  assign w_target    = (jmp_i ? pc_jmp_i : pc_branch_i) & ~32'h3;
  assign imem_addr_o = (r_state == S_DROP) ? r_drop_pc : r_fetch_pc;
  assign pc_o        = r_pc;
  assign inst_o      = r_inst;
  assign valid_o     = r_valid;
`ifdef IF_BUF_EN
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [31:0] r_buf_pc [BUF_DEPTH];
  logic [31:0] r_buf_inst [BUF_DEPTH];
  logic [PW-1:0] r_wp, w_wp, r_rp, w_rp;
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_push, w_pop;
  // A raised request is counted as outstanding; count cannot rise until it is acked.
  assign imem_req_o = (r_state == S_REQ && r_cnt < CW'(BUF_DEPTH)) || r_state == S_DROP;
  assign w_push = !if_flush_i && r_state == S_REQ && imem_req_o && imem_ack_i;
  assign w_pop  = !if_flush_i && !stall_i && r_cnt != '0;
  always_comb begin
    w_state    = r_state;
    w_fetch_pc = w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
    w_drop_pc  = r_drop_pc;
    w_pc       = w_pop ? r_buf_pc[r_rp] : r_pc;
    w_inst     = w_pop ? r_buf_inst[r_rp] : (stall_i ? r_inst : NOP_INST);
    w_valid    = w_pop ? 1'b1 : (stall_i && r_valid);
    w_wp       = w_push ? ((r_wp == PW'(BUF_DEPTH - 1)) ? '0 : r_wp + 1'b1) : r_wp;
    w_rp       = w_pop ? ((r_rp == PW'(BUF_DEPTH - 1)) ? '0 : r_rp + 1'b1) : r_rp;
    w_cnt      = r_cnt + CW'(w_push) - CW'(w_pop);
    if (r_state == S_IDLE) w_state = S_REQ;
    if (r_state == S_DROP && imem_ack_i) w_state = S_REQ;
    if (if_flush_i) begin
      w_fetch_pc = w_target;
      w_inst     = NOP_INST;
      w_valid    = 1'b0;
      w_wp       = '0;
      w_rp       = '0;
      w_cnt      = '0;
      w_state    = (imem_req_o && !imem_ack_i) ? S_DROP : S_REQ;
      w_drop_pc  = (r_state == S_REQ) ? r_fetch_pc : r_drop_pc;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wp;
      r_rp  <= w_rp;
      r_cnt <= w_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wp]   <= r_fetch_pc;
      r_buf_inst[r_wp] <= imem_rdata_i;
    end
  end
`else
  logic [31:0] r_hold_pc, w_hold_pc, r_hold_inst, w_hold_inst;
  assign imem_req_o = r_state == S_REQ || r_state == S_DROP;
  always_comb begin
    w_state     = r_state;
    w_fetch_pc  = r_fetch_pc;
    w_drop_pc   = r_drop_pc;
    w_pc        = r_pc;
    w_inst      = stall_i ? r_inst : NOP_INST;
    w_valid     = stall_i && r_valid;
    w_hold_pc   = r_hold_pc;
    w_hold_inst = r_hold_inst;
    if (if_flush_i) begin
      w_fetch_pc = w_target;
      w_inst     = NOP_INST;
      w_valid    = 1'b0;
      w_state    = (imem_req_o && !imem_ack_i) ? S_DROP : S_REQ;
      w_drop_pc  = (r_state == S_REQ) ? r_fetch_pc : r_drop_pc;
    end else begin
      case (r_state)
        S_IDLE: w_state = S_REQ;
        S_REQ: if (imem_ack_i) begin
          w_fetch_pc = r_fetch_pc + 32'd4;
          if (stall_i) begin
            w_hold_pc   = r_fetch_pc;
            w_hold_inst = imem_rdata_i;
            w_state     = S_HOLD;
          end else begin
            w_pc    = r_fetch_pc;
            w_inst  = imem_rdata_i;
            w_valid = 1'b1;
          end
        end
        S_HOLD: if (!stall_i) begin
          w_pc    = r_hold_pc;
          w_inst  = r_hold_inst;
          w_valid = 1'b1;
          w_state = S_REQ;
        end
        default: w_state = imem_ack_i ? S_REQ : S_DROP;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_pc   <= '0;
      r_hold_inst <= NOP_INST;
    end else begin
      r_hold_pc   <= w_hold_pc;
      r_hold_inst <= w_hold_inst;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_drop_pc  <= RESET_PC;
      r_pc       <= '0;
      r_inst     <= NOP_INST;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_fetch_pc <= w_fetch_pc;
      r_drop_pc  <= w_drop_pc;
      r_pc       <= w_pc;
      r_inst     <= w_inst;
      r_valid    <= w_valid;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch against hand-computed IF/ID and imem port values.
// The instruction memory returns 0xA0000000 | address so each word identifies its PC.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, stall_i, if_flush_i, jmp_i, imem_ack_i;
  logic [31:0] pc_branch_i, pc_jmp_i, imem_rdata_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, pc_o, inst_o;
  int checks = 0;
  int failures = 0;
  inst_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .if_flush_i(if_flush_i), .jmp_i(jmp_i),
    .pc_branch_i(pc_branch_i), .pc_jmp_i(pc_jmp_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );
  always #5 clk = ~clk;
  assign imem_rdata_i = 32'hA000_0000 | imem_addr_o;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".inst"}, inst_o, inst);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
  endtask
  task automatic port(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, 32'(imem_req_o), 32'(req));
    if (req) chk({tag, ".addr"}, imem_addr_o, addr);
  endtask
  initial begin
    rst = 1'b1; stall_i = 1'b0; if_flush_i = 1'b0; jmp_i = 1'b0;
    pc_branch_i = '0; pc_jmp_i = '0; imem_ack_i = 1'b1;
    #1;
    ifid("reset", 32'h0, 32'h13, 1'b0);
    port("reset", 1'b0, 32'h0);
    step(); step();
    rst = 1'b0;
`ifdef IF_BUF_EN
    step(); port("b_e1", 1'b1, 32'h0); ifid("b_e1", 32'h0, 32'h13, 1'b0);
    step(); ifid("b_e2", 32'h0, 32'h13, 1'b0);
    step(); ifid("b_e3", 32'h0, 32'hA000_0000, 1'b1);
    stall_i = 1'b1;
    step(); port("b_fill", 1'b0, 32'h0); ifid("b_fill", 32'h0, 32'hA000_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); port("b_full", 1'b0, 32'h0); ifid("b_full", 32'h0, 32'hA000_0000, 1'b1);
    end
    stall_i = 1'b0;
    step(); ifid("b_rel0", 32'h4, 32'hA000_0004, 1'b1); port("b_rel0", 1'b1, 32'hC);
    step(); ifid("b_rel1", 32'h8, 32'hA000_0008, 1'b1);
    step(); ifid("b_rel2", 32'hC, 32'hA000_000C, 1'b1);
`else
    step(); port("t1_e1", 1'b1, 32'h0); ifid("t1_e1", 32'h0, 32'h13, 1'b0);
    step(); port("t1_e2", 1'b1, 32'h4); ifid("t1_e2", 32'h0, 32'hA000_0000, 1'b1);
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); port("t2_wait", 1'b1, 32'h4); ifid("t2_wait", 32'h0, 32'h13, 1'b0);
    end
    imem_ack_i = 1'b1;
    step(); port("t2_ack", 1'b1, 32'h8); ifid("t2_ack", 32'h4, 32'hA000_0004, 1'b1);
    stall_i = 1'b1;
    step(); port("t3_s1", 1'b0, 32'h0); ifid("t3_s1", 32'h4, 32'hA000_0004, 1'b1);
    step(); port("t3_s2", 1'b0, 32'h0); ifid("t3_s2", 32'h4, 32'hA000_0004, 1'b1);
    stall_i = 1'b0;
    step(); port("t3_rel", 1'b1, 32'hC); ifid("t3_rel", 32'h8, 32'hA000_0008, 1'b1);
    imem_ack_i = 1'b0;
    step(); ifid("t4_wait", 32'h8, 32'h13, 1'b0);
    if_flush_i = 1'b1; jmp_i = 1'b1; pc_jmp_i = 32'h100;
    step(); port("t4_drop", 1'b1, 32'hC); ifid("t4_drop", 32'h8, 32'h13, 1'b0);
    if_flush_i = 1'b0; jmp_i = 1'b0;
    step(); port("t4_drop2", 1'b1, 32'hC);
    imem_ack_i = 1'b1;
    step(); port("t4_tgt", 1'b1, 32'h100); ifid("t4_disc", 32'h8, 32'h13, 1'b0);
    step(); ifid("t4_land", 32'h100, 32'hA000_0100, 1'b1);
    if_flush_i = 1'b1; stall_i = 1'b1; pc_branch_i = 32'h41;
    step(); port("t5_tgt", 1'b1, 32'h40); ifid("t5_bub", 32'h100, 32'h13, 1'b0);
    if_flush_i = 1'b0; stall_i = 1'b0;
    step(); ifid("t5_land", 32'h40, 32'hA000_0040, 1'b1);
    if_flush_i = 1'b1; jmp_i = 1'b1; pc_jmp_i = 32'hFFFF_FFFC;
    step(); port("wrap_tgt", 1'b1, 32'hFFFF_FFFC);
    if_flush_i = 1'b0; jmp_i = 1'b0;
    step(); port("wrap_next", 1'b1, 32'h0); ifid("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    imem_ack_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    port("rst_mid", 1'b0, 32'h0); ifid("rst_mid", 32'h0, 32'h13, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
